train_scheduler: RTL and testbench



---
 rtl/train_scheduler_pkg.sv | 23 ++
 rtl/train_scheduler_if.sv | 41 ++++
 rtl/train_scheduler_watchdog.sv | 43 ++++
 rtl/train_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_train_scheduler.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/train_scheduler_pkg.sv
// Shared state encoding and default sizing for the training-run scheduler.
package train_sched_pkg;

  localparam int LAYER_ADDR_WIDTH_DEF = 2;
  localparam int LAYER_MAX_DEF        = 3;
  localparam int SAMPLE_ADDR_SIZE_DEF = 10;
  localparam int MAX_SAMPLES_DEF      = 1000;
  localparam int EPOCH_WIDTH_DEF      = 8;
  localparam int ERR_WIDTH_DEF        = 16;
  localparam int WDOG_LIMIT_DEF       = 4096;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FP_ISSUE = 3'd1,
    FP_WAIT  = 3'd2,
    FP_STORE = 3'd3,
    BP_ISSUE = 3'd4,
    BP_WAIT  = 3'd5,
    NEXT     = 3'd6,
    DONE     = 3'd7
  } state_e;

endpackage

// File: rtl/train_scheduler_if.sv
// Control/status and datapath handshake bundle between the training top level,
// the scheduler and the forward/backprop/stack datapath.
interface train_sched_if
  import train_sched_pkg::*;
#(
  parameter int LAYER_ADDR_WIDTH = LAYER_ADDR_WIDTH_DEF,
  parameter int SAMPLE_ADDR_SIZE = SAMPLE_ADDR_SIZE_DEF,
  parameter int EPOCH_WIDTH      = EPOCH_WIDTH_DEF,
  parameter int ERR_WIDTH        = ERR_WIDTH_DEF
) ();

  logic                        start;
  logic                        abort;
  logic [EPOCH_WIDTH-1:0]      epochs;
  logic                        fp_start;
  logic                        fp_valid;
  logic                        bp_start;
  logic                        bp_valid;
  logic                        bp_error;
  logic                        stack_wr_en;
  logic [LAYER_ADDR_WIDTH-1:0] current_layer;
  logic [SAMPLE_ADDR_SIZE-1:0] current_sample;
  logic [EPOCH_WIDTH-1:0]      current_epoch;
  logic [ERR_WIDTH-1:0]        err_count;
  logic                        busy;
  logic                        done;
  logic                        timeout;

  modport sched (
    input  start, abort, epochs, fp_valid, bp_valid, bp_error,
    output fp_start, bp_start, stack_wr_en, current_layer, current_sample,
           current_epoch, err_count, busy, done, timeout
  );

  modport env (
    output start, abort, epochs, fp_valid, bp_valid, bp_error,
    input  fp_start, bp_start, stack_wr_en, current_layer, current_sample,
           current_epoch, err_count, busy, done, timeout
  );

endinterface

// File: rtl/train_scheduler_watchdog.sv
// Wait-state watchdog: counts cycles spent waiting on the datapath and raises a
// sticky timeout when the limit is hit. Only built with TRAIN_WATCHDOG_EN.
module sched_watchdog #(
  parameter int WDOG_LIMIT = 4096,
  localparam int CNT_W     = $clog2(WDOG_LIMIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic waiting_i,
  input  logic valid_i,
  output logic expire_o,
  output logic timeout_o
);

  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;

  // A response arriving on the final cycle still wins over the expiry.
  assign expire_o  = waiting_i && !valid_i && (cnt_q == CNT_W'(WDOG_LIMIT - 1));
  assign timeout_o = timeout_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q     <= {CNT_W{1'b0}};
      timeout_q <= 1'b0;
    end else begin
      if (waiting_i) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else begin
        cnt_q <= {CNT_W{1'b0}};
      end
      if (clear_i) begin
        timeout_q <= 1'b0;
      end else if (expire_o) begin
        timeout_q <= 1'b1;
      end else begin
        timeout_q <= timeout_q;
      end
    end
  end

endmodule

// File: rtl/train_scheduler.sv
// Training-run sequencer: forward layers up, backward layers down, per sample and
// per epoch. Optional wait-state watchdog enabled by the TRAIN_WATCHDOG_EN macro.
module train_scheduler
  import train_sched_pkg::*;
#(
  parameter int LAYER_ADDR_WIDTH = LAYER_ADDR_WIDTH_DEF,
  parameter int LAYER_MAX        = LAYER_MAX_DEF,
  parameter int SAMPLE_ADDR_SIZE = SAMPLE_ADDR_SIZE_DEF,
  parameter int MAX_SAMPLES      = MAX_SAMPLES_DEF,
  parameter int EPOCH_WIDTH      = EPOCH_WIDTH_DEF,
  parameter int ERR_WIDTH        = ERR_WIDTH_DEF,
  parameter int WDOG_LIMIT       = WDOG_LIMIT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  train_sched_if.sched bus
);

  localparam logic [LAYER_ADDR_WIDTH-1:0] LAST_LAYER  = LAYER_ADDR_WIDTH'(LAYER_MAX - 1);
  localparam logic [SAMPLE_ADDR_SIZE-1:0] LAST_SAMPLE = SAMPLE_ADDR_SIZE'(MAX_SAMPLES - 1);

  if (LAYER_MAX < 2 || LAYER_MAX > 2**LAYER_ADDR_WIDTH) begin : g_bad_layer_max
    $error("train_scheduler: LAYER_MAX out of range");
  end
  if (MAX_SAMPLES < 1 || MAX_SAMPLES > 2**SAMPLE_ADDR_SIZE) begin : g_bad_max_samples
    $error("train_scheduler: MAX_SAMPLES out of range");
  end
  if (WDOG_LIMIT < 1) begin : g_bad_wdog_limit
    $error("train_scheduler: WDOG_LIMIT must be positive");
  end

  state_e                      state_q, state_d;
  logic [LAYER_ADDR_WIDTH-1:0] layer_q, layer_d;
  logic [SAMPLE_ADDR_SIZE-1:0] sample_q, sample_d;
  logic [EPOCH_WIDTH-1:0]      epoch_q, epoch_d;
  logic [EPOCH_WIDTH-1:0]      epochs_q, epochs_d;
  logic [ERR_WIDTH-1:0]        err_q, err_d;
  logic                        fp_start_q, bp_start_q, wr_en_q, busy_q, done_q;
  logic                        start_acc_s, abort_s, wdog_fire_s, timeout_s;

  assign start_acc_s = (state_q == IDLE) && bus.start && (bus.epochs != {EPOCH_WIDTH{1'b0}});
  assign abort_s     = bus.abort && (state_q != IDLE);

`ifdef TRAIN_WATCHDOG_EN
  logic waiting_s, wait_valid_s;

  assign waiting_s    = ((state_q == FP_WAIT) || (state_q == BP_WAIT)) && !abort_s;
  assign wait_valid_s = (state_q == FP_WAIT) ? bus.fp_valid : bus.bp_valid;

  sched_watchdog #(.WDOG_LIMIT(WDOG_LIMIT)) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (start_acc_s),
    .waiting_i (waiting_s),
    .valid_i   (wait_valid_s),
    .expire_o  (wdog_fire_s),
    .timeout_o (timeout_s)
  );
`else
  assign wdog_fire_s = 1'b0;
  assign timeout_s   = 1'b0;
`endif

  // Next-state and counter updates; abort overrides everything and freezes counters.
  always_comb begin
    state_d  = state_q;
    layer_d  = layer_q;
    sample_d = sample_q;
    epoch_d  = epoch_q;
    epochs_d = epochs_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (start_acc_s) begin
          state_d  = FP_ISSUE;
          epochs_d = bus.epochs;
          err_d    = {ERR_WIDTH{1'b0}};
          layer_d  = {LAYER_ADDR_WIDTH{1'b0}};
          sample_d = {SAMPLE_ADDR_SIZE{1'b0}};
          epoch_d  = {EPOCH_WIDTH{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      FP_ISSUE: state_d = FP_WAIT;
      FP_WAIT: begin
        if (bus.fp_valid) begin
          state_d = FP_STORE;
        end else if (wdog_fire_s) begin
          state_d = IDLE;
        end else begin
          state_d = FP_WAIT;
        end
      end
      FP_STORE: begin
        if (layer_q == LAST_LAYER) begin
          state_d = BP_ISSUE;
        end else begin
          layer_d = layer_q + LAYER_ADDR_WIDTH'(1);
          state_d = FP_ISSUE;
        end
      end
      BP_ISSUE: state_d = BP_WAIT;
      BP_WAIT: begin
        if (bus.bp_valid) begin
          if (bus.bp_error && (err_q != {ERR_WIDTH{1'b1}})) begin
            err_d = err_q + ERR_WIDTH'(1);
          end else begin
            err_d = err_q;
          end
          if (layer_q == LAYER_ADDR_WIDTH'(1)) begin
            state_d = NEXT;
          end else begin
            layer_d = layer_q - LAYER_ADDR_WIDTH'(1);
            state_d = BP_ISSUE;
          end
        end else if (wdog_fire_s) begin
          state_d = IDLE;
        end else begin
          state_d = BP_WAIT;
        end
      end
      NEXT: begin
        layer_d = {LAYER_ADDR_WIDTH{1'b0}};
        if (sample_q < LAST_SAMPLE) begin
          sample_d = sample_q + SAMPLE_ADDR_SIZE'(1);
          state_d  = FP_ISSUE;
        end else begin
          sample_d = {SAMPLE_ADDR_SIZE{1'b0}};
          if (epoch_q == epochs_q - EPOCH_WIDTH'(1)) begin
            state_d = DONE;
          end else begin
            epoch_d = epoch_q + EPOCH_WIDTH'(1);
            state_d = FP_ISSUE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_s) begin
      state_d  = IDLE;
      layer_d  = layer_q;
      sample_d = sample_q;
      epoch_d  = epoch_q;
      epochs_d = epochs_q;
      err_d    = err_q;
    end else begin
      state_d = state_d;
    end
  end

  // State, counters and registered outputs; pulses decode the state being entered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      layer_q    <= {LAYER_ADDR_WIDTH{1'b0}};
      sample_q   <= {SAMPLE_ADDR_SIZE{1'b0}};
      epoch_q    <= {EPOCH_WIDTH{1'b0}};
      epochs_q   <= {EPOCH_WIDTH{1'b0}};
      err_q      <= {ERR_WIDTH{1'b0}};
      fp_start_q <= 1'b0;
      bp_start_q <= 1'b0;
      wr_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      layer_q    <= layer_d;
      sample_q   <= sample_d;
      epoch_q    <= epoch_d;
      epochs_q   <= epochs_d;
      err_q      <= err_d;
      fp_start_q <= (state_d == FP_ISSUE);
      bp_start_q <= (state_d == BP_ISSUE);
      wr_en_q    <= (state_d == FP_STORE);
      busy_q     <= (state_d != IDLE);
      done_q     <= (state_d == DONE);
    end
  end

  assign bus.fp_start       = fp_start_q;
  assign bus.bp_start       = bp_start_q;
  assign bus.stack_wr_en    = wr_en_q;
  assign bus.current_layer  = layer_q;
  assign bus.current_sample = sample_q;
  assign bus.current_epoch  = epoch_q;
  assign bus.err_count      = err_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.timeout        = timeout_s;

endmodule

// File: tb/tb_train_scheduler.sv
// Directed bench for train_scheduler (LAYER_MAX=3, MAX_SAMPLES=2) with a
// 3-cycle datapath responder; watchdog case only when TRAIN_WATCHDOG_EN is set.
module tb_train_scheduler;
  import train_sched_pkg::*;

  localparam int LW = 2, LM = 3, SW = 10, MS = 2, EW = 8, ERRW = 16, WL = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  train_sched_if #(.LAYER_ADDR_WIDTH(LW), .SAMPLE_ADDR_SIZE(SW),
                   .EPOCH_WIDTH(EW), .ERR_WIDTH(ERRW)) bus ();

  train_scheduler #(.LAYER_ADDR_WIDTH(LW), .LAYER_MAX(LM), .SAMPLE_ADDR_SIZE(SW),
                    .MAX_SAMPLES(MS), .EPOCH_WIDTH(EW), .ERR_WIDTH(ERRW),
                    .WDOG_LIMIT(WL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Controls owned by the main sequence
  logic        resp_en   = 1'b1;
  logic        abort_arm = 1'b0;
  logic [31:0] err_pat   = 32'd0;
  int          bpv_base  = 0;
  int          stray_req = 0;

  // Observations owned by the responder
  int          n_fp = 0, n_bp = 0, n_wr = 0, n_done = 0, n_bpv = 0, ep_n = 0;
  int          bpv_at_done = 0, stray_ack = 0, fp_cd = 0, bp_cd = 0;
  logic [31:0] fp_acc = 32'd0, bp_acc = 32'd0, ep_acc = 32'd0;

  // Datapath model: answers each start 3 cycles later and records output activity.
  initial begin
    int k;
    bus.fp_valid = 1'b0;
    bus.bp_valid = 1'b0;
    bus.bp_error = 1'b0;
    bus.abort    = 1'b0;
    forever begin
      @(negedge clk);
      bus.fp_valid = 1'b0;
      bus.bp_valid = 1'b0;
      bus.bp_error = 1'b0;
      bus.abort    = 1'b0;
      if (fp_cd > 0) begin
        fp_cd--;
        if (fp_cd == 0) bus.fp_valid = 1'b1;
      end
      if (bp_cd > 0) begin
        bp_cd--;
        if (bp_cd == 0) begin
          k = n_bpv - bpv_base;
          bus.bp_valid = 1'b1;
          bus.bp_error = err_pat[k[4:0]];
          n_bpv++;
          if (abort_arm) bus.abort = 1'b1;
        end
      end
      if (stray_req != stray_ack) begin
        bus.bp_valid = 1'b1;
        bus.bp_error = 1'b1;
        stray_ack    = stray_req;
      end
      if (bus.fp_start) begin
        n_fp++;
        fp_acc = {fp_acc[29:0], bus.current_layer};
        if (bus.current_layer == 2'd0 && bus.current_sample == 10'd0) begin
          ep_acc = {ep_acc[29:0], bus.current_epoch[1:0]};
          ep_n++;
        end
        if (resp_en) fp_cd = 3;
      end
      if (bus.bp_start) begin
        n_bp++;
        bp_acc = {bp_acc[29:0], bus.current_layer};
        if (resp_en) bp_cd = 3;
      end
      if (bus.stack_wr_en) n_wr++;
      if (bus.done) begin
        n_done++;
        bpv_at_done = n_bpv;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start_run(input logic [EW-1:0] e);
    bus.epochs = e;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget);
    for (int i = 0; i < budget && n_done == base; i++) tick();
    check_eq("done_within_budget", 32'(n_done != base), 32'd1);
  endtask

  initial begin
    int f0, w0, b0, d0, e0, v0;
    bus.start  = 1'b0;
    bus.epochs = 8'd0;
    rst = 1'b0;
    repeat (3) tick();
    check_eq("rst_busy",   32'(bus.busy), 32'd0);
    check_eq("rst_layer",  32'(bus.current_layer), 32'd0);
    check_eq("rst_sample", 32'(bus.current_sample), 32'd0);
    check_eq("rst_epoch",  32'(bus.current_epoch), 32'd0);
    check_eq("rst_err",    32'(bus.err_count), 32'd0);
    check_eq("rst_pulses", 32'({bus.fp_start, bus.bp_start, bus.stack_wr_en, bus.done, bus.timeout}), 32'd0);
    rst = 1'b1;
    tick();

    // Nominal: one epoch, two samples
    f0 = n_fp; w0 = n_wr; b0 = n_bp; d0 = n_done;
    start_run(8'd1);
    check_eq("lat_fp_start", 32'(bus.fp_start), 32'd1);
    check_eq("nom_busy", 32'(bus.busy), 32'd1);
    wait_done(d0, 500);
    check_eq("nom_done_pulse", 32'(bus.done), 32'd1);
    check_eq("nom_done_sample", 32'(bus.current_sample), 32'd0);
    tick();
    check_eq("nom_done_single", 32'(bus.done), 32'd0);
    check_eq("nom_idle_busy", 32'(bus.busy), 32'd0);
    check_eq("nom_fp_count", 32'(n_fp - f0), 32'd6);
    check_eq("nom_fp_layers", 32'(fp_acc[11:0]), 32'h186);
    check_eq("nom_wr_count", 32'(n_wr - w0), 32'd6);
    check_eq("nom_bp_count", 32'(n_bp - b0), 32'd4);
    check_eq("nom_bp_layers", 32'(bp_acc[7:0]), 32'h99);
    check_eq("nom_done_count", 32'(n_done - d0), 32'd1);

    // Epoch wrap: three epochs
    f0 = n_fp; e0 = ep_n; v0 = n_bpv; d0 = n_done;
    start_run(8'd3);
    wait_done(d0, 2000);
    tick();
    check_eq("ep_fp_count", 32'(n_fp - f0), 32'd18);
    check_eq("ep_epoch_starts", 32'(ep_n - e0), 32'd3);
    check_eq("ep_epoch_seq", 32'(ep_acc[5:0]), 32'h06);
    check_eq("ep_done_after_bpv", 32'(bpv_at_done - v0), 32'd12);
    check_eq("ep_epoch_held", 32'(bus.current_epoch), 32'd2);
    check_eq("ep_done_count", 32'(n_done - d0), 32'd1);

    // Error counting, then a stray bp_valid while idle
    bpv_base = n_bpv;
    err_pat  = 32'b1011;
    d0 = n_done;
    start_run(8'd1);
    check_eq("err_cleared_on_start", 32'(bus.err_count), 32'd0);
    wait_done(d0, 500);
    check_eq("err_count", 32'(bus.err_count), 32'd3);
    tick();
    stray_req++;
    tick();
    tick();
    check_eq("err_stray_ignored", 32'(bus.err_count), 32'd3);
    check_eq("err_stray_busy", 32'(bus.busy), 32'd0);

    // Abort coincident with bp_valid (which carries an error)
    bpv_base  = n_bpv;
    err_pat   = 32'hFFFF_FFFF;
    abort_arm = 1'b1;
    d0 = n_done;
    start_run(8'd1);
    for (int i = 0; i < 200 && bus.abort !== 1'b1; i++) tick();
    check_eq("abort_reached", 32'(bus.abort), 32'd1);
    check_eq("abort_with_bpv", 32'(bus.bp_valid), 32'd1);
    tick();
    abort_arm = 1'b0;
    check_eq("abort_busy", 32'(bus.busy), 32'd0);
    check_eq("abort_err_held", 32'(bus.err_count), 32'd0);
    check_eq("abort_layer_held", 32'(bus.current_layer), 32'd2);
    check_eq("abort_bp_start", 32'(bus.bp_start), 32'd0);
    repeat (8) tick();
    check_eq("abort_no_done", 32'(n_done - d0), 32'd0);

    // Reset in FP_WAIT at layer 1, sample 1
    start_run(8'd1);
    for (int i = 0; i < 300 && !(bus.fp_start === 1'b1 && bus.current_layer == 2'd1 &&
                                 bus.current_sample == 10'd1); i++) tick();
    check_eq("rstrun_reached", 32'({bus.fp_start, bus.current_layer}), 32'd5);
    check_eq("rstrun_err_before", 32'(bus.err_count), 32'd2);
    tick();
    rst = 1'b0;
    tick();
    check_eq("rstrun_busy", 32'(bus.busy), 32'd0);
    check_eq("rstrun_addr", 32'({bus.current_layer, bus.current_sample}), 32'd0);
    check_eq("rstrun_err", 32'(bus.err_count), 32'd0);
    check_eq("rstrun_pulses", 32'({bus.fp_start, bus.bp_start, bus.stack_wr_en, bus.done}), 32'd0);
    rst = 1'b1;
    start_run(8'd0);
    check_eq("zero_epochs_busy", 32'(bus.busy), 32'd0);
    tick();
    check_eq("zero_epochs_fp", 32'({bus.busy, bus.fp_start}), 32'd0);
    repeat (5) tick();

`ifdef TRAIN_WATCHDOG_EN
    resp_en = 1'b0;
    start_run(8'd1);
    check_eq("wd_fp_start", 32'(bus.fp_start), 32'd1);
    repeat (16) tick();
    check_eq("wd_not_yet", 32'({bus.busy, bus.timeout}), 32'd2);
    tick();
    check_eq("wd_timeout", 32'({bus.busy, bus.timeout}), 32'd1);
    resp_en = 1'b1;
    d0 = n_done;
    start_run(8'd1);
    check_eq("wd_cleared", 32'(bus.timeout), 32'd0);
    wait_done(d0, 500);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got expired expected finished");
    $fatal(1);
  end

endmodule
